// File: rtl/clock_divider_bank.sv
// clock_divider_bank
//   Bank of NCH independent run-time programmable clock dividers on one system clock.
//   Each channel produces a 50%-duty divided clock and a one-cycle tick in the first
//   system-clock cycle where its divided clock is high. Output frequency = f_clk / (2*div).
//   New divisors are held in a per-channel shadow and only take effect on a half-period
//   boundary (or immediately on sync, or at once on an idle channel), so no runt pulses.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   en           global enable; 0 freezes every channel
//   sync         synchronous restart of all channels (phase align), applies pending divisors
//   cfg_we       divisor write strobe
//   cfg_ch       channel index for the write (indices >= NCH are ignored)
//   cfg_div      new half-period divisor (0 = channel off)
//   cfg_pending  bit i set while a written divisor waits for its boundary
//   clk_out      divided clocks
//   tick         one-cycle pulse in the first cycle where clk_out[i] is high
module clock_divider_bank #(
  parameter int unsigned  NCH         = 4,
  parameter int unsigned  WIDTH       = 32,
  parameter int unsigned  DEFAULT_DIV = 50000,
  localparam int unsigned CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  output logic [NCH-1:0]   cfg_pending,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr;
    logic             idle;
    logic             boundary;

    assign wr       = cfg_we && (cfg_ch == CHW'(i));
    assign idle     = (div_q == '0);
    assign boundary = !idle && (cnt_q == div_q - One);

    always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;

      // A write always lands in the shadow; the branches below decide if it is consumed.
      if (wr) begin
        shadow_d = cfg_div;
        pend_d   = 1'b1;
      end

      if (sync) begin
        cnt_d = '0;
        clk_d = 1'b0;
        // The previously pending value is applied; a same-cycle write stays pending.
        if (pend_q) begin
          div_d  = shadow_q;
          pend_d = wr;
        end
      end else if (en) begin
        if (idle) begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (!wr && pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
          end
        end else if (boundary) begin
          cnt_d  = '0;
          clk_d  = ~clk_q;
          tick_d = ~clk_q;
          // A write in the boundary cycle bypasses the shadow entirely.
          if (wr) begin
            div_d  = cfg_div;
            pend_d = 1'b0;
          end else if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + One;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q    <= '0;
        div_q    <= WIDTH'(DEFAULT_DIV);
        shadow_q <= '0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        shadow_q <= shadow_d;
        pend_q   <= pend_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    assign cfg_pending[i] = pend_q;
    assign clk_out[i]     = clk_q;
    assign tick[i]        = tick_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: directed scenarios plus a randomized run,
// all compared against a per-channel behavioural model kept in "cycles left" form.
module tb_clock_divider_bank;

  localparam int unsigned NCH         = 5;
  localparam int unsigned WIDTH       = 32;
  localparam int unsigned DEFAULT_DIV = 50000;
  localparam int unsigned CHW         = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en;
  logic             sync;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [NCH-1:0]   cfg_pending;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  int errors = 0;
  int checks = 0;

  // Model: divisor, shadow, and cycles left in the current half-period.
  int unsigned    m_div    [NCH];
  int unsigned    m_shadow [NCH];
  int unsigned    m_left   [NCH];
  logic [NCH-1:0] m_pend;
  logic [NCH-1:0] m_clk;
  logic [NCH-1:0] m_tick;

  always #5 clk = ~clk;

  clock_divider_bank #(
    .NCH        (NCH),
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sync       (sync),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_pending(cfg_pending),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  function automatic logic [3*NCH-1:0] exp_all();
    return {m_pend, m_clk, m_tick};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i]    = DEFAULT_DIV;
      m_shadow[i] = 0;
      m_left[i]   = DEFAULT_DIV;
    end
    m_pend = '0;
    m_clk  = '0;
    m_tick = '0;
  endtask

  // One rising edge of the reference behaviour, from the inputs present at that edge.
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit wr;
      wr = cfg_we && (int'(cfg_ch) == i);
      m_tick[i] = 1'b0;
      if (sync) begin
        if (m_pend[i]) begin
          m_div[i]  = m_shadow[i];
          m_pend[i] = 1'b0;
        end
        m_left[i] = m_div[i];
        m_clk[i]  = 1'b0;
        if (wr) begin
          m_shadow[i] = cfg_div;
          m_pend[i]   = 1'b1;
        end
      end else if (!en) begin
        if (wr) begin
          m_shadow[i] = cfg_div;
          m_pend[i]   = 1'b1;
        end
      end else if (m_div[i] == 0) begin
        m_clk[i] = 1'b0;
        if (wr) begin
          m_shadow[i] = cfg_div;
          m_pend[i]   = 1'b1;
        end else if (m_pend[i]) begin
          m_div[i]  = m_shadow[i];
          m_pend[i] = 1'b0;
          m_left[i] = m_div[i];
        end
      end else if (m_left[i] == 1) begin
        m_tick[i] = !m_clk[i];
        m_clk[i]  = !m_clk[i];
        if (wr) begin
          m_div[i]  = cfg_div;
          m_pend[i] = 1'b0;
        end else if (m_pend[i]) begin
          m_div[i]  = m_shadow[i];
          m_pend[i] = 1'b0;
        end
        m_left[i] = m_div[i];
      end else begin
        m_left[i] = m_left[i] - 1;
        if (wr) begin
          m_shadow[i] = cfg_div;
          m_pend[i]   = 1'b1;
        end
      end
    end
  endtask

  // Advance one clock: model follows the edge, outputs are then sampled at the negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (clk_out !== '0) begin errors++; $display("FAIL rst_clk: got %b expected 0", clk_out); end
    checks++; if (tick !== '0) begin errors++; $display("FAIL rst_tick: got %b expected 0", tick); end
    checks++; if (cfg_pending !== '0) begin errors++; $display("FAIL rst_pend: got %b expected 0", cfg_pending); end
    rst = 1'b1;
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 32'd1; cycle(); cfg_we = 1'b0;
    sync = 1'b1; cycle(); sync = 1'b0;
    for (int k = 1; k <= 123; k++) begin
      if (k == 10) begin cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 32'd7; end
      cycle();
      cfg_we = 1'b0;
      checks++;
      if ({cfg_pending, clk_out, tick} !== exp_all()) begin
        errors++; $display("FAIL t1_model: got %b expected %b", {cfg_pending, clk_out, tick}, exp_all());
      end
    end
    checks++; if (cfg_pending[2] !== 1'b1) begin errors++; $display("FAIL t1_pend_before: got %b expected 1", cfg_pending[2]); end
    // Asynchronous assertion between edges must clear outputs without a clock.
    #2 rst = 1'b0;
    #1;
    checks++; if (clk_out !== '0) begin errors++; $display("FAIL t1_async_clk: got %b expected 0", clk_out); end
    checks++; if (tick !== '0) begin errors++; $display("FAIL t1_async_tick: got %b expected 0", tick); end
    checks++; if (cfg_pending !== '0) begin errors++; $display("FAIL t1_async_pend: got %b expected 0", cfg_pending); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    begin
      int n;
      n = 0;
      while (clk_out[0] !== 1'b1 && n < int'(DEFAULT_DIV) + 10) begin
        cycle();
        n++;
      end
      checks++; if (n != int'(DEFAULT_DIV)) begin errors++; $display("FAIL t1_first_rise: got %0d expected %0d", n, DEFAULT_DIV); end
    end
    checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL t1_first_tick: got %b expected 1", tick[0]); end
    checks++;
    if ({cfg_pending, clk_out, tick} !== exp_all()) begin
      errors++; $display("FAIL t1_model_end: got %b expected %b", {cfg_pending, clk_out, tick}, exp_all());
    end
  endtask

  task automatic test_frequency();
    int   rises[$];
    int   highs;
    int   ticks;
    logic prev;
    highs = 0;
    ticks = 0;
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 32'd3; cycle(); cfg_we = 1'b0;
    sync = 1'b1; cycle(); sync = 1'b0;
    prev = clk_out[1];
    for (int k = 1; k <= 30; k++) begin
      cycle();
      checks++;
      if ({cfg_pending, clk_out, tick} !== exp_all()) begin
        errors++; $display("FAIL t2_model: got %b expected %b", {cfg_pending, clk_out, tick}, exp_all());
      end
      if (clk_out[1] === 1'b1) highs++;
      if (tick[1] === 1'b1) ticks++;
      if (clk_out[1] === 1'b1 && prev === 1'b0) rises.push_back(k);
      prev = clk_out[1];
    end
    checks++; if (rises.size() != 5) begin errors++; $display("FAIL t2_rises: got %0d expected 5", rises.size()); end
    for (int j = 1; j < rises.size(); j++) begin
      checks++;
      if (rises[j] - rises[j-1] != 6) begin
        errors++; $display("FAIL t2_period: got %0d expected 6", rises[j] - rises[j-1]);
      end
    end
    checks++; if (highs != 15) begin errors++; $display("FAIL t2_duty: got %0d expected 15", highs); end
    checks++; if (ticks != 5) begin errors++; $display("FAIL t2_ticks: got %0d expected 5", ticks); end
    checks++; if (clk_out[0] !== 1'b0) begin errors++; $display("FAIL t2_ch0: got %b expected 0", clk_out[0]); end
  endtask

  task automatic test_reload();
    int   n;
    int   toggles;
    logic prev;
    cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 32'd10; cycle(); cfg_we = 1'b0;
    sync = 1'b1; cycle(); sync = 1'b0;
    repeat (4) cycle();
    cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 32'd2; cycle(); cfg_we = 1'b0;
    n = 0;
    while (cfg_pending[2] === 1'b1 && n < 20) begin
      n++;
      cycle();
      checks++;
      if ({cfg_pending, clk_out, tick} !== exp_all()) begin
        errors++; $display("FAIL t3_model: got %b expected %b", {cfg_pending, clk_out, tick}, exp_all());
      end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL t3_pend_len: got %0d expected 5", n); end
    toggles = 0;
    prev = clk_out[2];
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (clk_out[2] !== prev) begin
        toggles++;
        checks++;
        if (k % 2 != 0) begin errors++; $display("FAIL t3_halfperiod: got toggle at %0d expected even", k); end
      end
      prev = clk_out[2];
    end
    checks++; if (toggles != 10) begin errors++; $display("FAIL t3_toggles: got %0d expected 10", toggles); end
  endtask

  task automatic test_corner();
    int n;
    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 32'd1; cycle(); cfg_we = 1'b0;
    sync = 1'b1; cycle(); sync = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      checks++;
      if (clk_out[3] !== logic'(k % 2)) begin errors++; $display("FAIL t4_div1_clk: got %b expected %0d", clk_out[3], k % 2); end
      checks++;
      if (tick[3] !== logic'(k % 2)) begin errors++; $display("FAIL t4_div1_tick: got %b expected %0d", tick[3], k % 2); end
    end
    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 32'd0; cycle(); cfg_we = 1'b0;
    checks++; if (cfg_pending[3] !== 1'b0) begin errors++; $display("FAIL t4_div0_pend: got %b expected 0", cfg_pending[3]); end
    cycle();
    checks++; if (clk_out[3] !== 1'b0) begin errors++; $display("FAIL t4_div0_clk: got %b expected 0", clk_out[3]); end
    repeat (3) begin
      cycle();
      checks++;
      if (clk_out[3] !== 1'b0 || tick[3] !== 1'b0) begin
        errors++; $display("FAIL t4_div0_hold: got %b%b expected 00", clk_out[3], tick[3]);
      end
    end
    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 32'd5; cycle(); cfg_we = 1'b0;
    checks++; if (cfg_pending[3] !== 1'b1) begin errors++; $display("FAIL t4_idle_pend: got %b expected 1", cfg_pending[3]); end
    cycle();
    checks++; if (cfg_pending[3] !== 1'b0) begin errors++; $display("FAIL t4_idle_apply: got %b expected 0", cfg_pending[3]); end
    n = 0;
    while (clk_out[3] !== 1'b1 && n < 20) begin
      cycle();
      n++;
      checks++;
      if ({cfg_pending, clk_out, tick} !== exp_all()) begin
        errors++; $display("FAIL t4_model: got %b expected %b", {cfg_pending, clk_out, tick}, exp_all());
      end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL t4_restart: got %0d expected 5", n); end
  endtask

  task automatic test_enable();
    int   n;
    int   t;
    logic frozen;
    n = 0;
    while (tick[1] !== 1'b1 && n < 20) begin cycle(); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL t5_wait_tick: got timeout expected tick"); end
    t = 1;
    cycle();
    en = 1'b0;
    frozen = clk_out[1];
    repeat (7) begin
      cycle();
      t++;
      checks++; if (tick !== '0) begin errors++; $display("FAIL t5_freeze_tick: got %b expected 0", tick); end
      checks++; if (clk_out[1] !== frozen) begin errors++; $display("FAIL t5_freeze_clk: got %b expected %b", clk_out[1], frozen); end
    end
    en = 1'b1;
    while (tick[1] !== 1'b1 && t < 40) begin
      cycle();
      t++;
      checks++;
      if ({cfg_pending, clk_out, tick} !== exp_all()) begin
        errors++; $display("FAIL t5_model: got %b expected %b", {cfg_pending, clk_out, tick}, exp_all());
      end
    end
    checks++; if (t != 13) begin errors++; $display("FAIL t5_stretch: got %0d expected 13", t); end
    // Sync in a cycle where ch1 would otherwise rise.
    n = 0;
    while (!(m_left[1] == 1 && m_clk[1] == 1'b0) && n < 20) begin cycle(); n++; end
    sync = 1'b1; cycle(); sync = 1'b0;
    checks++; if (clk_out[1] !== 1'b0) begin errors++; $display("FAIL t5_sync_clk: got %b expected 0", clk_out[1]); end
    checks++; if (tick[1] !== 1'b0) begin errors++; $display("FAIL t5_sync_tick: got %b expected 0", tick[1]); end
    n = 0;
    while (clk_out[1] !== 1'b1 && n < 20) begin cycle(); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL t5_sync_restart: got %0d expected 3", n); end
  endtask

  task automatic test_writes();
    int   n;
    logic prev;
    sync = 1'b1; cycle(); sync = 1'b0;
    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 32'd8; cycle();
    cfg_div = 32'd4; cycle(); cfg_we = 1'b0;
    checks++; if (cfg_pending[3] !== 1'b1) begin errors++; $display("FAIL t6_pend: got %b expected 1", cfg_pending[3]); end
    n = 0;
    while (cfg_pending[3] === 1'b1 && n < 20) begin cycle(); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL t6_apply_at: got %0d expected 3", n); end
    prev = clk_out[3];
    n = 0;
    while (clk_out[3] === prev && n < 20) begin cycle(); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL t6_last_wins: got %0d expected 4", n); end
    cfg_we = 1'b1; cfg_ch = 3'(NCH); cfg_div = 32'd1; cycle();
    cfg_ch = 3'd7; cycle(); cfg_we = 1'b0;
    checks++; if (cfg_pending !== '0) begin errors++; $display("FAIL t6_ignored: got %b expected 0", cfg_pending); end
    repeat (10) begin
      cycle();
      checks++;
      if ({cfg_pending, clk_out, tick} !== exp_all()) begin
        errors++; $display("FAIL t6_model: got %b expected %b", {cfg_pending, clk_out, tick}, exp_all());
      end
    end
    n = 0;
    while (m_left[1] != 1 && n < 20) begin cycle(); n++; end
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 32'd2; cycle(); cfg_we = 1'b0;
    checks++; if (cfg_pending[1] !== 1'b0) begin errors++; $display("FAIL t6_bypass_pend: got %b expected 0", cfg_pending[1]); end
    prev = clk_out[1];
    n = 0;
    while (clk_out[1] === prev && n < 20) begin cycle(); n++; end
    checks++; if (n != 2) begin errors++; $display("FAIL t6_bypass_div: got %0d expected 2", n); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      en      = ($urandom_range(0, 9) != 0);
      sync    = ($urandom_range(0, 49) == 0);
      cfg_we  = ($urandom_range(0, 3) == 0);
      cfg_ch  = 3'($urandom_range(0, 7));
      cfg_div = 32'($urandom_range(0, 6));
      cycle();
      checks++;
      if ({cfg_pending, clk_out, tick} !== exp_all()) begin
        errors++; $display("FAIL rnd_model: cycle %0d got %b expected %b", k, {cfg_pending, clk_out, tick}, exp_all());
      end
    end
    en = 1'b1; sync = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    en      = 1'b1;
    sync    = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    #1 rst = 1'b0;
    model_reset();
    test_reset();
    test_frequency();
    test_reload();
    test_corner();
    test_enable();
    test_writes();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
